// File: rtl/periph_bridge_pkg.sv
// Shared types and peripheral address-window constants for periph_noc_bridge.
package periph_bridge_pkg;

    localparam logic [39:0] PERIPH_WIN_HI       = 40'h0000004000;
    localparam logic [3:0]  PERIPH_WIN_MAX_PAGE = 4'h5;
    // Storage width for the echoed ID; the bridge uses the low ID_W bits.
    localparam int unsigned BRIDGE_ID_MAX_W     = 16;

    typedef enum logic [1:0] {
        StIdle,
        StWaitAck,
        StResp
    } bridge_state_e;

    typedef struct packed {
        logic                       we;
        logic [55:0]                addr;
        logic [127:0]               wdata;
        logic [BRIDGE_ID_MAX_W-1:0] id;
    } bridge_req_t;

    function automatic logic addr_decode_ok(input logic [39:0] hi, input logic [3:0] page,
                                            input logic [2:0] lsb);
        return (hi == PERIPH_WIN_HI) && (page <= PERIPH_WIN_MAX_PAGE) && (lsb == 3'b000);
    endfunction

endpackage

// File: rtl/periph_noc_bridge.sv
// Single-outstanding fabric-to-peripheral-NoC bridge with address-window decode.
// Optional WAIT_ACK timeout enabled by defining PERIPH_BRIDGE_TIMEOUT_EN.
module periph_noc_bridge
    import periph_bridge_pkg::*;
#(
    parameter int unsigned ID_W           = 4,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            s_req_valid,
    output logic            s_req_ready,
    input  logic            s_req_we,
    input  logic [55:0]     s_req_addr,
    input  logic [127:0]    s_req_wdata,
    input  logic [ID_W-1:0] s_req_id,
    output logic            s_rsp_valid,
    input  logic            s_rsp_ready,
    output logic [127:0]    s_rsp_rdata,
    output logic [ID_W-1:0] s_rsp_id,
    output logic            s_rsp_err,
    output logic            noc_req,
    output logic            noc_we,
    output logic [55:0]     noc_addr,
    output logic [127:0]    noc_wdata,
    input  logic            noc_ack,
    input  logic [127:0]    noc_rdata
);

    bridge_state_e state_q, state_d;
    bridge_req_t   req_q, req_d;
    logic [127:0]  rdata_q, rdata_d;
    logic          err_q, err_d;
    logic          timeout;

`ifdef PERIPH_BRIDGE_TIMEOUT_EN
    logic [15:0] wait_cnt_q;

    // Held at zero outside WAIT_ACK, so it starts from zero on every entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
        end else if (state_q != StWaitAck) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_q + 16'd1;
        end
    end

    assign timeout = (state_q == StWaitAck) && (wait_cnt_q == 16'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            req_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (s_req_valid) begin
                    req_d.we    = s_req_we;
                    req_d.addr  = s_req_addr;
                    req_d.wdata = s_req_wdata;
                    req_d.id    = BRIDGE_ID_MAX_W'(s_req_id);
                    if (addr_decode_ok(s_req_addr[55:16], s_req_addr[15:12], s_req_addr[2:0])) begin
                        state_d = StWaitAck;
                    end else begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                        state_d = StResp;
                    end
                end
            end
            StWaitAck: begin
                // An ack in the timeout cycle takes priority over the timeout.
                if (noc_ack) begin
                    rdata_d = req_q.we ? '0 : noc_rdata;
                    err_d   = 1'b0;
                    state_d = StResp;
                end else if (timeout) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = StResp;
                end
            end
            StResp: begin
                if (s_rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Ready is gated by reset so it reads 0 for the whole reset interval.
    assign s_req_ready = (state_q == StIdle) && rst_n;
    assign s_rsp_valid = (state_q == StResp);
    assign s_rsp_rdata = rdata_q;
    assign s_rsp_id    = req_q.id[ID_W-1:0];
    assign s_rsp_err   = err_q;
    assign noc_req     = (state_q == StWaitAck);
    assign noc_we      = req_q.we;
    assign noc_addr    = req_q.addr;
    assign noc_wdata   = req_q.wdata;

    logic unused_id_hi;
    assign unused_id_hi = ^req_q.id;

endmodule

// File: tb/tb_periph_noc_bridge.sv
// Self-checking bench for periph_noc_bridge: vector table, scoreboard, peripheral model.
module tb_periph_noc_bridge;

    localparam int TO = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         s_req_valid = 1'b0;
    logic         s_req_ready;
    logic         s_req_we = 1'b0;
    logic [55:0]  s_req_addr = '0;
    logic [127:0] s_req_wdata = '0;
    logic [3:0]   s_req_id = '0;
    logic         s_rsp_valid;
    logic         s_rsp_ready = 1'b0;
    logic [127:0] s_rsp_rdata;
    logic [3:0]   s_rsp_id;
    logic         s_rsp_err;
    logic         noc_req;
    logic         noc_we;
    logic [55:0]  noc_addr;
    logic [127:0] noc_wdata;
    logic         noc_ack = 1'b0;
    logic [127:0] noc_rdata = '0;

    periph_noc_bridge #(.ID_W(4), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_we(s_req_we),
        .s_req_addr(s_req_addr), .s_req_wdata(s_req_wdata), .s_req_id(s_req_id),
        .s_rsp_valid(s_rsp_valid), .s_rsp_ready(s_rsp_ready), .s_rsp_rdata(s_rsp_rdata),
        .s_rsp_id(s_rsp_id), .s_rsp_err(s_rsp_err),
        .noc_req(noc_req), .noc_we(noc_we), .noc_addr(noc_addr), .noc_wdata(noc_wdata),
        .noc_ack(noc_ack), .noc_rdata(noc_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         we;
        logic [55:0]  addr;
        logic [127:0] wdata;
        logic [3:0]   id;
        logic [127:0] mrdata;
        int           ack_at;   // req-high cycle in which the model acks; 0 = never
        logic         exp_err;
        int           exp_lat;  // cycles from acceptance to first s_rsp_valid
        int           exp_req;  // cycles noc_req is high
    } vec_t;

    typedef struct {
        logic [127:0] rdata;
        logic [3:0]   id;
        logic         err;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;

    // Peripheral model state (written only by the model process below).
    int  run = 0;
    int  req_total = 0;
    int  fld_bad = 0;
    // Model controls (written only by the main process).
    logic         m_we = 1'b0;
    logic [55:0]  m_addr = '0;
    logic [127:0] m_wdata = '0;
    logic [127:0] model_rdata = '0;
    int           ack_at = 0;
    logic         stray_ack = 1'b0;

    always @(negedge clk) begin
        if (noc_req) begin
            run = run + 1;
            req_total = req_total + 1;
            if (noc_we !== m_we || noc_addr !== m_addr || noc_wdata !== m_wdata)
                fld_bad = fld_bad + 1;
            noc_ack = (ack_at > 0) && (run == ack_at);
            noc_rdata = noc_ack ? model_rdata : 128'hbad0_bad0;
        end else begin
            run = 0;
            noc_ack = stray_ack;
            noc_rdata = 128'hfeed_f00d;
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_txn(input vec_t v, input string tag, input int hold);
        exp_t e, got;
        int   lat, req0, bad0;
        bit   seen;
        logic [127:0] h_rdata;
        logic [3:0]   h_id;
        logic         h_err;
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (s_req_ready) begin seen = 1; break; end
        end
        chk({tag, " idle_ready"}, 128'(seen), 128'd1);
        e.err = v.exp_err;
        e.id = v.id;
        e.rdata = (v.exp_err || v.we) ? 128'd0 : v.mrdata;
        sb.push_back(e);
        req0 = req_total;
        bad0 = fld_bad;
        m_we = v.we; m_addr = v.addr; m_wdata = v.wdata;
        ack_at = v.ack_at; model_rdata = v.mrdata;
        s_req_valid = 1'b1; s_req_we = v.we; s_req_addr = v.addr;
        s_req_wdata = v.wdata; s_req_id = v.id;
        @(posedge clk);
        #1;
        s_req_valid = 1'b0;
        s_req_we = ~v.we;
        s_req_addr = {24'h0, $urandom()};
        s_req_wdata = {4{$urandom()}};
        s_req_id = ~v.id;
        seen = 0; lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (s_rsp_valid) begin lat = i; seen = 1; break; end
        end
        chk({tag, " rsp_seen"}, 128'(seen), 128'd1);
        got = sb.pop_front();
        if (seen) begin
            chk({tag, " latency"}, 128'(lat), 128'(v.exp_lat));
            chk({tag, " rdata"}, s_rsp_rdata, got.rdata);
            chk({tag, " id"}, 128'(s_rsp_id), 128'(got.id));
            chk({tag, " err"}, 128'(s_rsp_err), 128'(got.err));
            chk({tag, " req_ready_in_resp"}, 128'(s_req_ready), 128'd0);
        end
        chk({tag, " noc_req_cycles"}, 128'(req_total - req0), 128'(v.exp_req));
        chk({tag, " noc_fields"}, 128'(fld_bad - bad0), 128'd0);
        if (hold > 0) begin
            h_rdata = s_rsp_rdata; h_id = s_rsp_id; h_err = s_rsp_err;
            s_req_valid = 1'b1; s_req_we = 1'b0; s_req_addr = 56'h4000_0020; s_req_id = 4'h6;
            stray_ack = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                chk($sformatf("%s stall%0d valid", tag, i), 128'(s_rsp_valid), 128'd1);
                chk($sformatf("%s stall%0d data", tag, i),
                    {s_rsp_rdata[123:0] ^ h_rdata[123:0], s_rsp_id ^ h_id}, 128'd0);
                chk($sformatf("%s stall%0d err", tag, i), 128'(s_rsp_err), 128'(h_err));
                chk($sformatf("%s stall%0d req_ready", tag, i), 128'(s_req_ready), 128'd0);
            end
            s_req_valid = 1'b0;
            stray_ack = 1'b0;
            chk({tag, " stall_no_accept"}, 128'(req_total - req0), 128'(v.exp_req));
        end
        s_rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        s_rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t vecs[7];
    vec_t v;
    bit   seen;

    initial begin
        vecs[0] = '{1'b1, 56'h4000_0000, 128'ha5, 4'd3, 128'h77, 2, 1'b0, 3, 2};
        vecs[1] = '{1'b0, 56'h4000_0010, 128'h0, 4'd5, 128'h1234, 2, 1'b0, 3, 2};
        vecs[2] = '{1'b1, 56'h4000_6000, 128'h55, 4'd7, 128'h0, 2, 1'b1, 1, 0};
        vecs[3] = '{1'b0, 56'h4000_0004, 128'h0, 4'd9, 128'h99, 2, 1'b1, 1, 0};
        vecs[4] = '{1'b0, 56'h4000_5ff8, 128'h0, 4'hc, 128'hdead_beef_0123_4567_89ab, 4,
                    1'b0, 5, 4};
        vecs[5] = '{1'b0, 56'h4001_0000, 128'h0, 4'd1, 128'h42, 2, 1'b1, 1, 0};
        vecs[6] = '{1'b1, 56'h4000_0008, 128'h1, 4'hf, 128'habcd, 1, 1'b0, 2, 1};

        #23;
        chk("reset req_ready", 128'(s_req_ready), 128'd0);
        chk("reset rsp_valid", 128'(s_rsp_valid), 128'd0);
        chk("reset noc_req", 128'(noc_req), 128'd0);
        chk("reset rsp_outs", {s_rsp_rdata[122:0], s_rsp_id, s_rsp_err}, 128'd0);
        chk("reset noc_outs", {noc_wdata[70:0], noc_addr, noc_we}, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset req_ready", 128'(s_req_ready), 128'd1);

        // Stray ack while idle must be ignored.
        stray_ack = 1'b1;
        repeat (2) @(negedge clk);
        stray_ack = 1'b0;
        @(negedge clk);
        chk("stray_idle rsp_valid", 128'(s_rsp_valid), 128'd0);
        chk("stray_idle noc_req", 128'(noc_req), 128'd0);
        chk("stray_idle req_ready", 128'(s_req_ready), 128'd1);

        for (int i = 0; i < 7; i++) run_txn(vecs[i], $sformatf("vec%0d", i), 0);

        // Response back-pressure for 10 cycles with a competing request.
        run_txn(vecs[1], "stall", 10);
        run_txn(vecs[6], "after_stall", 0);

        // Reset pulse while waiting for an ack.
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (s_req_ready) begin seen = 1; break; end
        end
        chk("rstmid idle_ready", 128'(seen), 128'd1);
        m_we = 1'b0; m_addr = 56'h4000_0100; m_wdata = 128'h0; ack_at = 0;
        s_req_valid = 1'b1; s_req_we = 1'b0; s_req_addr = 56'h4000_0100; s_req_id = 4'h2;
        @(posedge clk);
        #1 s_req_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("rstmid noc_req_before", 128'(noc_req), 128'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid noc_req_async", 128'(noc_req), 128'd0);
        chk("rstmid rsp_valid", 128'(s_rsp_valid), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (s_rsp_valid || noc_req) seen = 1;
        end
        chk("rstmid no_response", 128'(seen), 128'd0);
        run_txn(vecs[1], "after_rst", 0);

`ifdef PERIPH_BRIDGE_TIMEOUT_EN
        v = '{1'b0, 56'h4000_0200, 128'h0, 4'h4, 128'h5151, 0, 1'b1, TO + 1, TO};
        run_txn(v, "timeout", 0);
        repeat (3) @(negedge clk);
        stray_ack = 1'b1;
        @(negedge clk);
        stray_ack = 1'b0;
        repeat (2) @(negedge clk);
        chk("late_ack rsp_valid", 128'(s_rsp_valid), 128'd0);
        chk("late_ack noc_req", 128'(noc_req), 128'd0);
        chk("late_ack req_ready", 128'(s_req_ready), 128'd1);
        v = '{1'b0, 56'h4000_0208, 128'h0, 4'h8, 128'h6262, TO, 1'b0, TO + 1, TO};
        run_txn(v, "ack_at_timeout", 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/periph_noc_bridge.md
# periph_noc_bridge

Single-outstanding request bridge between the SoC fabric and the peripheral subsystem's NoC slave port. It accepts fabric requests over a valid/ready channel, checks them against the peripheral address window, and drives the `noc_req`/`noc_ack` level handshake into the peripheral subsystem. Each request produces exactly one response on a valid/ready channel back to the fabric, including error responses for bad addresses and, optionally, timeouts. It sits directly upstream of the peripheral subsystem and is its only master.

## Interface
Parameters:
- `ID_W`, default 4: width of the fabric transaction ID, echoed unchanged on the response.
- `TIMEOUT_CYCLES`, default 256: cycles `WAIT_ACK` may last before a timeout error; legal range 2..65535.

Ports:
- `clk`, in, 1: single clock for the whole block.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `s_req_valid`, in, 1: fabric request valid.
- `s_req_ready`, out, 1: bridge can accept a request.
- `s_req_we`, in, 1: 1 = write, 0 = read.
- `s_req_addr`, in, 56: byte address.
- `s_req_wdata`, in, 128: write data.
- `s_req_id`, in, `ID_W`: transaction ID.
- `s_rsp_valid`, out, 1: response valid.
- `s_rsp_ready`, in, 1: fabric accepts the response.
- `s_rsp_rdata`, out, 128: read data; 0 for writes and errors.
- `s_rsp_id`, out, `ID_W`: echoed ID.
- `s_rsp_err`, out, 1: 1 = decode, alignment or timeout error.
- `noc_req`, out, 1: request level to the peripheral subsystem.
- `noc_we`, out, 1: write enable to the peripheral subsystem.
- `noc_addr`, out, 56: address to the peripheral subsystem.
- `noc_wdata`, out, 128: write data to the peripheral subsystem.
- `noc_ack`, in, 1: one-cycle acknowledge from the peripheral subsystem.
- `noc_rdata`, in, 128: read data, valid in the `noc_ack` cycle.

## Operation
- FSM states: `IDLE`, `WAIT_ACK`, `RESP`.
- `IDLE`:
  - `s_req_ready` = 1.
  - On `s_req_valid`, register we, addr, wdata and id, then run the decode check.
  - Decode pass goes to `WAIT_ACK`. Decode fail goes straight to `RESP` with `err` = 1 and `rdata` = 0, and no downstream access is made.
- Decode rule: `addr[55:16]` == 40'h0000004000, `addr[15:12]` ≤ 4'h5, and `addr[2:0]` == 0. Otherwise the request is an error.
- `WAIT_ACK`:
  - `noc_req` = 1. `noc_we`, `noc_addr` and `noc_wdata` hold the registered request, stable for the whole state.
  - When `noc_ack` = 1 is sampled: capture `noc_rdata`, or 0 if the request is a write, set `err` = 0, and go to `RESP`.
  - `noc_req` falls at that same clock edge.
- `RESP`:
  - `s_rsp_valid` = 1. `rdata`, `id` and `err` are held stable until `s_rsp_ready`, then return to `IDLE`.
  - `s_req_ready` = 0 throughout.
- `noc_ack` sampled outside `WAIT_ACK` (a stray or late ack) is ignored and changes no state or output.
- Only one transaction is ever outstanding; there is no reordering.
- `noc_req` is never 1 in two back-to-back transactions without at least one intervening low cycle. This is guaranteed by the `RESP` state.

## Timing
- Reset values: `s_req_ready` = 0 while `rst_n` is low and 1 from the first cycle after release. All other outputs are 0. The FSM is in `IDLE`.
- Nominal read or write, with acceptance in cycle 0:
  - `noc_req` is high in cycle 1.
  - The peripheral acks in cycle 2.
  - `s_rsp_valid` is high in cycle 3.
  - Turnaround latency is 3 cycles.
- Decode error: `s_rsp_valid` is high in cycle 1, with no `noc_req` pulse.
- Back-to-back requests: next acceptance is at the earliest in the cycle after the response handshake. Peak throughput is one transaction per 4 cycles.
- Reset asserted mid-transaction: the transaction is dropped with no response. `noc_req` goes to 0 asynchronously.

## Configuration
- Macro: `PERIPH_BRIDGE_TIMEOUT_EN`.
- Defined:
  - A 16-bit counter clears on entry to `WAIT_ACK` and increments each cycle there.
  - When it reaches `TIMEOUT_CYCLES - 1` without an ack: drop `noc_req`, go to `RESP` with `err` = 1 and `rdata` = 0.
  - Ack and timeout in the same cycle: the ack wins and `err` = 0.
- Not defined: there is no counter, and `WAIT_ACK` waits indefinitely for `noc_ack`.

## Structure
- Package `periph_bridge_pkg` holds:
  - the state enum `bridge_state_e`;
  - window constants `PERIPH_WIN_HI` (40'h4000) and `PERIPH_WIN_MAX_PAGE` (4'h5);
  - the request struct `bridge_req_t` (we, addr, wdata, id).
- No sub-module. FSM, request register and optional counter live in one module.

## Test plan
- Write to 56'h4000_0000 with wdata 0xA5, id 3; peripheral model acks 1 cycle after req -> `noc_req` high exactly 1 cycle before ack, then response with id 3, err 0, rdata 0 at cycle 3.
- Read 56'h4000_0010 with the model returning 0x1234 -> `s_rsp_rdata` = 0x1234, err 0, id echoed.
- Request to 56'h4000_6000 and request to 56'h4000_0004 -> each responds at cycle 1 with err 1 and rdata 0; `noc_req` never rises.
- `s_rsp_ready` held low for 10 cycles -> `s_rsp_valid`, data and id stable throughout, `s_req_ready` = 0, a new `s_req_valid` is not accepted.
- With `PERIPH_BRIDGE_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 8, no ack -> `noc_req` high for 8 cycles then low, response err 1. A late ack 3 cycles later is ignored. Repeat with the ack in cycle 8: err 0.
- `rst_n` pulsed low during `WAIT_ACK` -> `noc_req` is 0 immediately, no response, and the next request completes normally.
